// File: rtl/alu_arbiter_pkg.sv
// Shared types and widths for the ALU arbiter and its requester interface.
// Opcode values (ALU_OP_*) belong to the ALU itself and are not repeated here.
package alu_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } alu_arb_state_t;

   localparam int ALU_CTRL_W = 4;
   localparam int ALU_DATA_W = 16;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: N_REQ request and response channels.
// With ALU_ARB_LOCK_EN defined the bundle also carries per-requester req_lock.
interface alu_arbiter_if #(
   parameter int N_REQ = 2
);
   import alu_arbiter_pkg::*;

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_ready;
   logic [ALU_CTRL_W*N_REQ-1:0] req_ctrl;
   logic [ALU_DATA_W*N_REQ-1:0] req_a;
   logic [ALU_DATA_W*N_REQ-1:0] req_b;
   logic [N_REQ-1:0]            rsp_valid;
   logic [N_REQ-1:0]            rsp_ready;
   logic [ALU_DATA_W-1:0]       rsp_y;

`ifdef ALU_ARB_LOCK_EN
   logic [N_REQ-1:0]            req_lock;

   modport master (
      output req_valid, req_ctrl, req_a, req_b, req_lock, rsp_ready,
      input  req_ready, rsp_valid, rsp_y
   );

   modport slave (
      input  req_valid, req_ctrl, req_a, req_b, req_lock, rsp_ready,
      output req_ready, rsp_valid, rsp_y
   );
`else
   modport master (
      output req_valid, req_ctrl, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_y
   );

   modport slave (
      input  req_valid, req_ctrl, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_y
   );
`endif

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req searching upward from
// last_gnt+1 (wrapping), returned both one-hot and as an index.
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   last_gnt,
   output logic [N_REQ-1:0] gnt,
   output logic [IDW-1:0]   gnt_idx,
   output logic             any
);

   int pos;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      pos     = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         pos = (int'(last_gnt) + k) % N_REQ;
         if (!any && req[pos]) begin
            gnt[pos] = 1'b1;
            gnt_idx  = IDW'(pos);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered 16-bit ALU between N_REQ requesters.
// Optional requester locking is compiled in with `define ALU_ARB_LOCK_EN.
//
//   state | meaning
//   IDLE  | arbitrate; accept at most one request
//   ISSUE | op registers presented to the ALU, sampled at end of cycle
//   WAIT  | alu_y valid, captured into res_q
//   RESP  | rsp_valid[gnt] held with res_q until rsp_ready[gnt]
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_arbiter_if.slave          bus,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic [ALU_DATA_W-1:0] alu_a,
   output logic [ALU_DATA_W-1:0] alu_b,
   input  logic [ALU_DATA_W-1:0] alu_y,
   output logic                  busy
);

   alu_arb_state_t state_q, state_d;

   logic [IDW-1:0]        gnt_q;
   logic [IDW-1:0]        last_gnt_q;
   logic [N_REQ-1:0]      gnt_oh;
   logic [N_REQ-1:0]      arb_req;
   logic [N_REQ-1:0]      pick_oh;
   logic [IDW-1:0]        pick_idx;
   logic                  pick_any;
   logic                  accept;
   logic [ALU_CTRL_W-1:0] op_ctrl_q;
   logic [ALU_DATA_W-1:0] op_a_q;
   logic [ALU_DATA_W-1:0] op_b_q;
   logic [ALU_DATA_W-1:0] res_q;

   assign gnt_oh = N_REQ'(1) << gnt_q;

`ifdef ALU_ARB_LOCK_EN
   logic lock_q;

   // While locked, only the requester that set the lock is eligible.
   assign arb_req = lock_q ? (bus.req_valid & gnt_oh) : bus.req_valid;
`else
   assign arb_req = bus.req_valid;
`endif

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_rr (
      .req      (arb_req),
      .last_gnt (last_gnt_q),
      .gnt      (pick_oh),
      .gnt_idx  (pick_idx),
      .any      (pick_any)
   );

   // Gated by reset so no request is acknowledged while reset is held.
   assign accept = (state_q == IDLE) && pick_any && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      busy          = 1'b1;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (accept) begin
               bus.req_ready = pick_oh;
               state_d       = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT:  state_d = RESP;
         RESP: begin
            bus.rsp_valid = gnt_oh;
            if (|(bus.rsp_ready & gnt_oh)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_q      <= '0;
         last_gnt_q <= IDW'(N_REQ - 1);
         op_ctrl_q  <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         res_q      <= '0;
`ifdef ALU_ARB_LOCK_EN
         lock_q     <= 1'b0;
`endif
      end else begin
         if (accept) begin
            gnt_q     <= pick_idx;
            op_ctrl_q <= bus.req_ctrl[pick_idx*ALU_CTRL_W +: ALU_CTRL_W];
            op_a_q    <= bus.req_a[pick_idx*ALU_DATA_W +: ALU_DATA_W];
            op_b_q    <= bus.req_b[pick_idx*ALU_DATA_W +: ALU_DATA_W];
`ifdef ALU_ARB_LOCK_EN
            if (!lock_q) begin
               last_gnt_q <= pick_idx;
            end
            lock_q <= bus.req_lock[pick_idx];
`else
            last_gnt_q <= pick_idx;
`endif
         end
         if (state_q == WAIT) begin
            res_q <= alu_y;
         end
      end
   end

   assign alu_ctrl  = op_ctrl_q;
   assign alu_a     = op_a_q;
   assign alu_b     = op_b_q;
   assign bus.rsp_y = res_q;

endmodule
